// File: rtl/tick_timer.sv
// Tick-driven down-counter with IDLE/RUN/PAUSE/DONE control and a reload register.
// Define TICK_TIMER_AUTORELOAD_EN for periodic mode (reload on expiry, stay in RUN).
module tick_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= (state_d == StRun);
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        // A load wins over start; stop wins over start.
        if (load) begin
          reload_d = load_val;
          count_d  = load_val;
        end else if (start && !stop && (count_q != '0)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StPause;
        end else if (tick) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            done_d = 1'b1;
`ifdef TICK_TIMER_AUTORELOAD_EN
            count_d = reload_q;
`else
            count_d = '0;
            state_d = StDone;
`endif
          end
        end
      end
      StPause: begin
        if (load) begin
          reload_d = load_val;
          count_d  = load_val;
        end else if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          state_d = StRun;
        end
      end
      StDone: begin
        if (load) begin
          reload_d = load_val;
          count_d  = load_val;
        end else if (stop) begin
          state_d = StIdle;
        end else if (start && (reload_q != '0)) begin
          count_d = reload_q;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_tick_timer.sv
// Scoreboarded directed bench for tick_timer: expectations queued per cycle, popped after each edge.
module tb_tick_timer;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick, start, stop, load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy, done;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  tick_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got 0 expected 1 entries", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".count"}, 32'(count), 32'(e.count));
    check({tag, ".busy"},  32'(busy),  32'(e.busy));
    check({tag, ".done"},  32'(done),  32'(e.done));
  endtask

  // Drive one cycle of inputs, queue the post-edge expectation, then compare after the edge.
  task automatic step(input string tag, input logic t, input logic sa, input logic so,
                      input logic ld, input logic [WIDTH-1:0] lv,
                      input logic [WIDTH-1:0] ec, input logic eb, input logic ed);
    exp_t e;
    tick = t; start = sa; stop = so; load = ld; load_val = lv;
    e.count = ec; e.busy = eb; e.done = ed;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_front(tag);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; tick = 0; start = 0; stop = 0; load = 0; load_val = '0;
    #3;
    e.count = '0; e.busy = 1'b0; e.done = 1'b0;
    exp_q.push_back(e);
    compare_front("reset");
    #4 rst = 1'b0;

`ifdef TICK_TIMER_AUTORELOAD_EN
    // Periodic: 2,1,2,1 with done on each reload, busy held.
    step("ar_load",  0, 0, 0, 1, 8'd2, 8'd2, 0, 0);
    step("ar_start", 0, 1, 0, 0, 8'd0, 8'd2, 1, 0);
    step("ar_t1",    1, 0, 0, 0, 8'd0, 8'd1, 1, 0);
    step("ar_t2",    1, 0, 0, 0, 8'd0, 8'd2, 1, 1);
    step("ar_t3",    1, 0, 0, 0, 8'd0, 8'd1, 1, 0);
    step("ar_t4",    1, 0, 0, 0, 8'd0, 8'd2, 1, 1);
    step("ar_t5",    1, 0, 0, 0, 8'd0, 8'd1, 1, 0);
    step("ar_stop",  1, 0, 1, 0, 8'd0, 8'd1, 0, 0);
    step("ar_idle",  0, 0, 1, 0, 8'd0, 8'd1, 0, 0);
`else
    // One-shot 3,2,1,0 with a single done pulse.
    step("os_load",  0, 0, 0, 1, 8'd3, 8'd3, 0, 0);
    step("os_start", 1, 1, 0, 0, 8'd0, 8'd3, 1, 0);
    step("os_t1",    1, 0, 0, 0, 8'd0, 8'd2, 1, 0);
    step("os_t2",    1, 0, 0, 0, 8'd0, 8'd1, 1, 0);
    step("os_t3",    1, 0, 0, 0, 8'd0, 8'd0, 0, 1);
    step("os_after", 1, 0, 0, 0, 8'd0, 8'd0, 0, 0);
    // Restart from DONE reloads 3; load during RUN is ignored.
    step("rl_start", 0, 1, 0, 0, 8'd0, 8'd3, 1, 0);
    step("rl_ldrun", 0, 0, 0, 1, 8'd9, 8'd3, 1, 0);
    step("rl_t1",    1, 0, 0, 0, 8'd0, 8'd2, 1, 0);
    step("rl_t2",    1, 0, 0, 0, 8'd0, 8'd1, 1, 0);
    step("rl_t3",    1, 0, 0, 0, 8'd0, 8'd0, 0, 1);
    step("rl_stop",  0, 0, 1, 0, 8'd0, 8'd0, 0, 0);
    // Zero count never starts; start+stop in IDLE stays put.
    step("z_load",   0, 0, 0, 1, 8'd0, 8'd0, 0, 0);
    step("z_start",  1, 1, 0, 0, 8'd0, 8'd0, 0, 0);
    step("z_start2", 0, 1, 0, 0, 8'd0, 8'd0, 0, 0);
    step("ss_load",  0, 0, 0, 1, 8'd4, 8'd4, 0, 0);
    step("ss_both",  0, 1, 1, 0, 8'd0, 8'd4, 0, 0);
    step("ss_hold",  0, 0, 0, 0, 8'd0, 8'd4, 0, 0);
    // Load with start applies the load only; then pause/resume sequence.
    step("ls_both",  0, 1, 0, 1, 8'd5, 8'd5, 0, 0);
    step("pr_start", 0, 1, 0, 0, 8'd0, 8'd5, 1, 0);
    step("pr_t1",    1, 0, 0, 0, 8'd0, 8'd4, 1, 0);
    step("pr_t2",    1, 0, 0, 0, 8'd0, 8'd3, 1, 0);
    step("pr_stopt", 1, 0, 1, 0, 8'd0, 8'd3, 0, 0);
    for (int i = 0; i < 3; i++) step("pr_ptick", 1, 0, 0, 0, 8'd0, 8'd3, 0, 0);
    step("pr_resume",0, 1, 0, 0, 8'd0, 8'd3, 1, 0);
    step("pr_t3",    1, 0, 0, 0, 8'd0, 8'd2, 1, 0);
    step("pr_t4",    1, 0, 0, 0, 8'd0, 8'd1, 1, 0);
    step("pr_t5",    1, 0, 0, 0, 8'd0, 8'd0, 0, 1);
    step("pr_after", 1, 0, 0, 0, 8'd0, 8'd0, 0, 0);
    // start+stop in PAUSE acts as stop -> IDLE; start then does nothing without count.
    step("ps_load",  0, 0, 0, 1, 8'd6, 8'd6, 0, 0);
    step("ps_start", 0, 1, 0, 0, 8'd0, 8'd6, 1, 0);
    step("ps_pause", 0, 0, 1, 0, 8'd0, 8'd6, 0, 0);
    step("ps_both",  0, 1, 1, 0, 8'd0, 8'd6, 0, 0);
    step("ps_idlet", 1, 0, 0, 0, 8'd0, 8'd6, 0, 0);
    step("ps_stop",  0, 0, 1, 0, 8'd0, 8'd6, 0, 0);
`endif

    // Reset mid-RUN between clock edges aborts with no done pulse.
    step("rs_load",  0, 0, 0, 1, 8'd4, 8'd4, 0, 0);
    step("rs_start", 0, 1, 0, 0, 8'd0, 8'd4, 1, 0);
    step("rs_t1",    1, 0, 0, 0, 8'd0, 8'd3, 1, 0);
    step("rs_t2",    1, 0, 0, 0, 8'd0, 8'd2, 1, 0);
    rst = 1'b1;
    #2;
    e.count = '0; e.busy = 1'b0; e.done = 1'b0;
    exp_q.push_back(e);
    compare_front("rs_async");
    #1 rst = 1'b0;
    step("rs_tick",  1, 0, 0, 0, 8'd0, 8'd0, 0, 0);
    step("rs_start2",1, 1, 0, 0, 8'd0, 8'd0, 0, 0);
    step("rs_idle",  0, 0, 0, 0, 8'd0, 8'd0, 0, 0);

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the bit width of the count, reload and load_val.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port tick  input  1  one-cycle timebase pulse from the upstream prescaler/tick generator.
REQ-005 SHALL have port start  input  1  start/resume request, sampled each clk edge.
REQ-006 SHALL have port stop  input  1  pause/abort request, sampled each clk edge.
REQ-007 SHALL have port load  input  1  load request for load_val.
REQ-008 SHALL have port load_val  input  WIDTH  initial/reload count value.
REQ-009 SHALL have port count  output  WIDTH  current remaining count, registered.
REQ-010 SHALL have port busy  output  1  high exactly while state is RUN, registered.
REQ-011 SHALL have port done  output  1  one-clk pulse on expiry, registered.

Function
REQ-012 SHALL implement a four-state FSM: IDLE, RUN, PAUSE, DONE; any unused encoding SHALL return to IDLE.
REQ-013 SHALL hold an internal WIDTH-bit reload register, written only by load.
REQ-014 load in IDLE, PAUSE or DONE SHALL set reload := load_val and count := load_val next edge, with the state unchanged; load in RUN SHALL be ignored.
REQ-015 IDLE: start with count != 0 and no stop SHALL go to RUN; start with count == 0 SHALL stay IDLE.
REQ-016 RUN: tick with count > 1 SHALL decrement count by 1; no tick SHALL hold count.
REQ-017 RUN: tick with count == 1 SHALL set count := 0, done := 1 for exactly one cycle, and next state DONE (without the macro).
REQ-018 RUN: stop SHALL go to PAUSE and hold count; a tick in the same cycle SHALL be ignored.
REQ-019 PAUSE: start without stop SHALL return to RUN with count unchanged; stop SHALL go to IDLE with count unchanged; tick SHALL be ignored.
REQ-020 DONE: count SHALL hold 0; start with reload != 0 SHALL set count := reload and go to RUN; stop SHALL go to IDLE.
REQ-021 start and stop asserted together SHALL act as stop alone in every state.
REQ-022 load and start in the same cycle (non-RUN state) SHALL apply the load and ignore the start.
REQ-023 count SHALL never wrap: decrement occurs only from values >= 1.
REQ-024 done SHALL be 0 in every cycle except the cycle following the expiry edge.

Reset
REQ-025 rst high SHALL immediately force state IDLE, count 0, reload 0, busy 0, done 0, regardless of clk.
REQ-026 rst asserted mid-RUN SHALL abort the countdown with no done pulse; operation SHALL resume only via a new load and start after rst deasserts.

Configuration
REQ-027 Macro TICK_TIMER_AUTORELOAD_EN SHALL select periodic mode.
REQ-028 With TICK_TIMER_AUTORELOAD_EN defined, expiry in RUN SHALL set count := reload, pulse done, and stay in RUN with busy high; DONE SHALL be unreachable.
REQ-029 Without TICK_TIMER_AUTORELOAD_EN, expiry SHALL follow REQ-017 (one-shot).

Verification
REQ-030 load_val=3, load, start, tick every cycle -> count 3,2,1,0; done one pulse at count 0 edge; state DONE; busy drops same edge.
REQ-031 load_val=5, start, 2 ticks, stop+tick same cycle, 3 idle ticks, start, ticks -> count holds at 3 through PAUSE, resumes 3,2,1,0, single done.
REQ-032 load_val=0, start -> stays IDLE, busy 0, no done; start+stop together in IDLE with count 4 -> stays IDLE.
REQ-033 load_val=4, start, rst pulse between clk edges at count 2 -> count 0, busy 0 immediately, no done; later start without load -> stays IDLE.
REQ-034 TICK_TIMER_AUTORELOAD_EN defined, load_val=2, start, continuous ticks -> count 2,1,2,1,...; done every 2nd tick; busy stays 1.
REQ-035 DONE state, start -> count reloads to last load_val (e.g. 3) and countdown repeats; load during RUN (load_val=9) -> ignored, count unaffected.
